// File: rtl/gray_capture_decoder.sv
// gray_capture_decoder
// Brings a gray-coded count from a foreign clock domain into clk, decodes it
// to binary, and queues requested captures in a small FIFO drained through a
// valid/ready handshake. Sticky flags report illegal multi-bit gray steps and
// captures dropped because the FIFO was full.
module gray_capture_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             capture,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic             err_multi_bit,
  output logic             overflow,
  input  logic             clear_flags
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_gs;
  logic [WIDTH-1:0] r_gs_prev;
  logic [WIDTH-1:0] r_dec_q;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             w_armed;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_last;

  logic             r_err;
  logic             r_ovf;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_err_set;

  // Binary value from gray: running XOR of all gray bits from the MSB down.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b            = '0;
    b[WIDTH-1]   = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic more_than_one_bit(input logic [WIDTH-1:0] d);
    return (d & (d - WIDTH'(1))) != '0;
  endfunction

  assign w_gs      = r_sync[SYNC_STAGES-1];
  assign w_armed   = (r_arm_cnt == ARM_DONE);

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = !w_empty && bin_ready;
  assign w_push    = capture && (!w_full || w_pop);
  assign w_drop    = capture && !w_push;
  assign w_err_set = w_armed && more_than_one_bit(w_gs ^ r_gs_prev);

  // When empty, bin_out keeps showing the most recently popped value.
  assign bin_out       = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];
  assign bin_valid     = !w_empty;
  assign err_multi_bit = r_err;
  assign overflow      = r_ovf;

  // Plain flop chain resynchronising each gray bit independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Registered decode, previous-sample memory and post-reset arming delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dec_q   <= '0;
      r_gs_prev <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_dec_q   <= gray_to_bin(w_gs);
      r_gs_prev <= w_gs;
      if (r_arm_cnt != ARM_DONE) begin
        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_dec_q;
    end
  end

  // FIFO pointers plus the held copy of the last value handed to the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_last   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // Sticky flags: a set event in the same cycle as clear_flags keeps the flag high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_err <= w_err_set | (r_err & ~clear_flags);
      r_ovf <= w_drop    | (r_ovf & ~clear_flags);
    end
  end

endmodule
